sram_bus_arbiter: RTL and testbench

//  Shares one sram-like memory port between the IF-stage instruction requester (m0)
//  and the EXE/MEM-stage data requester (m1). Sits between the mycpu_top stages and
//  the memory-side bridge.

---
 rtl/sram_bus_arbiter_if.sv | 21 ++
 rtl/sram_bus_arbiter.sv | 82 ++++++++
 tb/tb_sram_bus_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_if.sv
// rtl/sram_bus_arbiter_if.sv - sram-like request/response bus bundle
interface sram_bus_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - two-requester sram bus arbiter with in-order response routing
module sram_bus_arbiter #(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    sram_bus_if.slave  m0,
    sram_bus_if.slave  m1,
    sram_bus_if.master s,
    output logic       err
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]          wptr;
    logic [PW-1:0]          rptr;
    logic [PW:0]            count;
    logic [SW-1:0]          starve_cnt;

    logic full;
    logic grant_m0;
    logic s_req_c;
    logic push;
    logic pop;
    logic head_m1;

    // Data side wins unless the instruction side has waited out STARVE_LIMIT grants.
    assign full     = (count == (PW+1)'(OUTSTANDING));
    assign grant_m0 = m0.req & (~m1.req | (starve_cnt >= SW'(STARVE_LIMIT)));
    assign s_req_c  = (m0.req | m1.req) & ~full;
    assign push     = s_req_c & s.addr_ok;
    assign pop      = s.data_ok & (count != '0);
    assign head_m1  = owner_q[rptr];

    assign s.req   = s_req_c;
    assign s.wr    = grant_m0 ? m0.wr    : m1.wr;
    assign s.size  = grant_m0 ? m0.size  : m1.size;
    assign s.addr  = grant_m0 ? m0.addr  : m1.addr;
    assign s.wdata = grant_m0 ? m0.wdata : m1.wdata;

    assign m0.addr_ok = push & grant_m0;
    assign m1.addr_ok = push & ~grant_m0;
    assign m0.data_ok = pop & ~head_m1;
    assign m1.data_ok = pop & head_m1;
    assign m0.rdata   = s.rdata;
    assign m1.rdata   = s.rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= '0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            starve_cnt <= '0;
            err        <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wptr] <= ~grant_m0;
                wptr          <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A response with nothing outstanding means memory and core disagree.
            if (s.data_ok && (count == '0)) begin
                err <= 1'b1;
            end
            if (!m0.req || (push && grant_m0)) begin
                starve_cnt <= '0;
            end else if (push && (starve_cnt != SW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;
    localparam int OUT = 4;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic reset;
    logic err;
    always #5 clk = ~clk;

    sram_bus_if m0_bus ();
    sram_bus_if m1_bus ();
    sram_bus_if s_bus ();

    sram_bus_arbiter #(.OUTSTANDING(OUT), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .err   (err)
    );

    int checks = 0;
    int errors = 0;
    int mq[$];
    int m_starve = 0;
    bit m_err = 1'b0;
    int ack_log[$];
    int dok_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit exp_grant_m0();
        return m0_bus.req && (!m1_bus.req || m_starve >= LIM);
    endfunction

    // Expected outputs from the queue model, checked every active cycle.
    always @(negedge clk) begin
        bit sreq, g0, pop;
        if (!reset) begin
            sreq = (m0_bus.req || m1_bus.req) && (mq.size() < OUT);
            g0   = exp_grant_m0();
            pop  = s_bus.data_ok && (mq.size() > 0);
            chk("s_req", s_bus.req, sreq);
            if (sreq) begin
                chk("s_addr",  s_bus.addr,  g0 ? m0_bus.addr  : m1_bus.addr);
                chk("s_wr",    s_bus.wr,    g0 ? m0_bus.wr    : m1_bus.wr);
                chk("s_size",  s_bus.size,  g0 ? m0_bus.size  : m1_bus.size);
                chk("s_wdata", s_bus.wdata, g0 ? m0_bus.wdata : m1_bus.wdata);
            end
            chk("m0_addr_ok", m0_bus.addr_ok, s_bus.addr_ok && sreq && g0);
            chk("m1_addr_ok", m1_bus.addr_ok, s_bus.addr_ok && sreq && !g0);
            chk("m0_data_ok", m0_bus.data_ok, pop && mq[0] == 0);
            chk("m1_data_ok", m1_bus.data_ok, pop && mq[0] == 1);
            chk("m0_rdata", m0_bus.rdata, s_bus.rdata);
            chk("m1_rdata", m1_bus.rdata, s_bus.rdata);
            chk("err", err, m_err);
            if (m0_bus.addr_ok) ack_log.push_back(0);
            if (m1_bus.addr_ok) ack_log.push_back(1);
            if (m0_bus.data_ok) dok_log.push_back(0);
            if (m1_bus.data_ok) dok_log.push_back(1);
        end
    end

    always @(posedge clk) begin
        bit sreq, g0, push, pop;
        if (reset) begin
            mq.delete();
            m_starve = 0;
            m_err    = 1'b0;
        end else begin
            sreq = (m0_bus.req || m1_bus.req) && (mq.size() < OUT);
            g0   = exp_grant_m0();
            push = sreq && s_bus.addr_ok;
            pop  = s_bus.data_ok && (mq.size() > 0);
            if (s_bus.data_ok && mq.size() == 0) m_err = 1'b1;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(g0 ? 0 : 1);
            if (!m0_bus.req) m_starve = 0;
            else if (push) m_starve = g0 ? 0 : ((m_starve < LIM) ? m_starve + 1 : LIM);
        end
    end

    task automatic cyc(input logic r, input logic q0, input logic q1, input logic aok,
                       input logic dok, input logic [31:0] rd = 32'h0);
        @(posedge clk);
        #1;
        reset          = r;
        m0_bus.req     = q0;
        m1_bus.req     = q1;
        s_bus.addr_ok  = aok;
        s_bus.data_ok  = dok;
        s_bus.rdata    = rd;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_bus.req = 1'b0; m0_bus.wr = 1'b0; m0_bus.size = 2'd2;
        m0_bus.addr = 32'hBFC0_0000; m0_bus.wdata = 32'h0;
        m1_bus.req = 1'b0; m1_bus.wr = 1'b1; m1_bus.size = 2'd2;
        m1_bus.addr = 32'h8000_1000; m1_bus.wdata = 32'h1234_5678;
        s_bus.addr_ok = 1'b0; s_bus.data_ok = 1'b0; s_bus.rdata = 32'h0;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_err", err, 0);
        chk("rst_s_req", s_bus.req, 0);
        chk("rst_m0_data_ok", m0_bus.data_ok, 0);
        chk("rst_m1_data_ok", m1_bus.data_ok, 0);

        // Instruction fetch only
        cyc(0, 1, 0, 1, 0);
        chk("t1_m0_addr_ok", m0_bus.addr_ok, 1);
        chk("t1_m1_addr_ok", m1_bus.addr_ok, 0);
        chk("t1_s_addr", s_bus.addr, 32'hBFC0_0000);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("t1_m0_data_ok", m0_bus.data_ok, 1);
        chk("t1_m1_data_ok", m1_bus.data_ok, 0);
        chk("t1_m0_rdata", m0_bus.rdata, 32'hDEAD_BEEF);

        // Collision: data side first, then instruction side
        dok_log.delete();
        cyc(0, 1, 1, 1, 0);
        chk("t2_s_addr", s_bus.addr, 32'h8000_1000);
        chk("t2_m1_addr_ok", m1_bus.addr_ok, 1);
        chk("t2_m0_addr_ok", m0_bus.addr_ok, 0);
        cyc(0, 1, 0, 1, 0);
        chk("t2_m0_addr_ok_next", m0_bus.addr_ok, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h0000_0011);
        cyc(0, 0, 0, 0, 1, 32'h0000_0022);
        chk("t2_dok_count", dok_log.size(), 2);
        if (dok_log.size() == 2) begin
            chk("t2_dok0", dok_log[0], 1);
            chk("t2_dok1", dok_log[1], 0);
        end

        // Starvation: four m1 grants, one m0 grant, m1 resumes
        ack_log.delete();
        cyc(0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 1, 1);
            if (i == 3) chk("t3_m0_wins", m0_bus.addr_ok, 1);
        end
        cyc(0, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
        begin
            int exp_seq[7] = '{1, 1, 1, 1, 0, 1, 0};
            chk("t3_ack_count", ack_log.size(), 7);
            if (ack_log.size() == 7)
                for (int i = 0; i < 7; i++) chk($sformatf("t3_ack%0d", i), ack_log[i], exp_seq[i]);
        end

        // Full: four pushes, bubble on the pop cycle, fifth accepted after
        ack_log.delete();
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        chk("t4_full_s_req", s_bus.req, 0);
        chk("t4_full_addr_ok", m0_bus.addr_ok, 0);
        cyc(0, 1, 0, 1, 1);
        chk("t4_pop_s_req", s_bus.req, 0);
        chk("t4_pop_data_ok", m0_bus.data_ok, 1);
        cyc(0, 1, 0, 1, 0);
        chk("t4_fifth_s_req", s_bus.req, 1);
        chk("t4_fifth_addr_ok", m0_bus.addr_ok, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
        chk("t4_ack_count", ack_log.size(), 5);

        // Push/pop at count 2 with pointer wrap
        cyc(1, 0, 0, 0, 0);
        dok_log.delete();
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        begin
            int exp_dok[6] = '{0, 1, 1, 0, 1, 0};
            chk("t5_dok_count", dok_log.size(), 6);
            if (dok_log.size() == 6)
                for (int i = 0; i < 6; i++) chk($sformatf("t5_dok%0d", i), dok_log[i], exp_dok[i]);
        end
        chk("t5_err", err, 0);

        // Spurious response while empty
        cyc(0, 0, 0, 0, 1);
        chk("t6_m0_data_ok", m0_bus.data_ok, 0);
        chk("t6_m1_data_ok", m1_bus.data_ok, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_err_set", err, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t6_err_sticky", err, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_err_cleared", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
